multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/control_pkg.sv | 68 ++++++
 rtl/mc_outdec.sv | 75 +++++++
 rtl/multicycle_control.sv | 115 +++++++++++
 tb/tb_multicycle_control.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the multicycle controller: state encodings, opcodes and the
// control-word payload.
package control_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;

  localparam logic [STATE_W-1:0] ST_FETCH    = 4'd0;
  localparam logic [STATE_W-1:0] ST_DECODE   = 4'd1;
  localparam logic [STATE_W-1:0] ST_MEMADR   = 4'd2;
  localparam logic [STATE_W-1:0] ST_MEMREAD  = 4'd3;
  localparam logic [STATE_W-1:0] ST_MEMWB    = 4'd4;
  localparam logic [STATE_W-1:0] ST_MEMWRITE = 4'd5;
  localparam logic [STATE_W-1:0] ST_EXECUTE  = 4'd6;
  localparam logic [STATE_W-1:0] ST_ALUWB    = 4'd7;
  localparam logic [STATE_W-1:0] ST_BRANCH   = 4'd8;
  localparam logic [STATE_W-1:0] ST_ADDIEXEC = 4'd9;
  localparam logic [STATE_W-1:0] ST_ADDIWB   = 4'd10;
  localparam logic [STATE_W-1:0] ST_JUMP     = 4'd11;

  localparam logic [OPCODE_W-1:0] R    = 6'b000000;
  localparam logic [OPCODE_W-1:0] LW   = 6'b100011;
  localparam logic [OPCODE_W-1:0] SW   = 6'b101011;
  localparam logic [OPCODE_W-1:0] BEQ  = 6'b000100;
  localparam logic [OPCODE_W-1:0] BNE  = 6'b000101;
  localparam logic [OPCODE_W-1:0] J    = 6'b000010;
  localparam logic [OPCODE_W-1:0] ADDI = 6'b001000;

  typedef enum logic [STATE_W-1:0] {
    FETCH    = ST_FETCH,
    DECODE   = ST_DECODE,
    MEMADR   = ST_MEMADR,
    MEMREAD  = ST_MEMREAD,
    MEMWB    = ST_MEMWB,
    MEMWRITE = ST_MEMWRITE,
    EXECUTE  = ST_EXECUTE,
    ALUWB    = ST_ALUWB,
    BRANCH   = ST_BRANCH,
    ADDIEXEC = ST_ADDIEXEC,
    ADDIWB   = ST_ADDIWB,
    JUMP     = ST_JUMP
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic       reg_write;
    logic       bne;
    logic [1:0] reg_dst;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_legal(input logic [OPCODE_W-1:0] op);
    return (op == R) || (op == LW) || (op == SW) || (op == BEQ) ||
           (op == BNE) || (op == J) || (op == ADDI);
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational control-word decoder: maps current state (plus opcode and memory
// handshake) onto the datapath enables and selects.
module mc_outdec
  import control_pkg::*;
(
  input  state_e              state,
  input  logic [OPCODE_W-1:0] op_q,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output ctrl_t               ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b  = 2'b11;
        ctrl.illegal    = !is_legal(opcode);
        ctrl.instr_done = !is_legal(opcode);
      end
      MEMADR, ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      MEMREAD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      MEMWRITE: begin
        ctrl.mem_write  = 1'b1;
        ctrl.ior_d      = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
      end
      ALUWB: begin
        ctrl.reg_dst    = 2'b01;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
        ctrl.bne           = (op_q == BNE);
        ctrl.instr_done    = 1'b1;
      end
      JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = 2'b10;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style controller: state/opcode registers and next-state logic,
// with output decoding delegated to mc_outdec.
module multicycle_control
  import control_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                memReady,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic                iorD,
  output logic                memRead,
  output logic                memWrite,
  output logic                irWrite,
  output logic                memToReg,
  output logic                aluSrcA,
  output logic                regWrite,
  output logic                bne,
  output logic [1:0]          regDst,
  output logic [1:0]          aluSrcB,
  output logic [1:0]          aluOp,
  output logic [1:0]          pcSource,
  output logic                instrDone,
  output logic                illegal,
  output logic [STATE_W-1:0]  state
);

  state_e              state_q, state_d, dec_state;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic                mem_ready;
  ctrl_t               dec_ctrl, out_ctrl;

  assign mem_ready = MEM_WAIT_EN ? memReady : 1'b1;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    unique case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        op_d = opcode;
        unique case (opcode)
          R:        state_d = EXECUTE;
          LW, SW:   state_d = MEMADR;
          BEQ, BNE: state_d = BRANCH;
          ADDI:     state_d = ADDIEXEC;
          J:        state_d = JUMP;
          default:  state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (op_q == SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) state_d = MEMWB;
      MEMWRITE: if (mem_ready) state_d = FETCH;
      EXECUTE:  state_d = ALUWB;
      ADDIEXEC: state_d = ADDIWB;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      op_q    <= R;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // During reset present FETCH selects with every write/pulse output forced low.
  assign dec_state = rst ? FETCH : state_q;

  mc_outdec u_outdec (
    .state     (dec_state),
    .op_q      (op_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (dec_ctrl)
  );

  always_comb begin
    out_ctrl = dec_ctrl;
    if (rst) begin
      out_ctrl.pc_write      = 1'b0;
      out_ctrl.pc_write_cond = 1'b0;
      out_ctrl.ir_write      = 1'b0;
      out_ctrl.mem_write     = 1'b0;
      out_ctrl.reg_write     = 1'b0;
      out_ctrl.instr_done    = 1'b0;
      out_ctrl.illegal       = 1'b0;
    end
  end

  assign pcWrite     = out_ctrl.pc_write;
  assign pcWriteCond = out_ctrl.pc_write_cond;
  assign iorD        = out_ctrl.ior_d;
  assign memRead     = out_ctrl.mem_read;
  assign memWrite    = out_ctrl.mem_write;
  assign irWrite     = out_ctrl.ir_write;
  assign memToReg    = out_ctrl.mem_to_reg;
  assign aluSrcA     = out_ctrl.alu_src_a;
  assign regWrite    = out_ctrl.reg_write;
  assign bne         = out_ctrl.bne;
  assign regDst      = out_ctrl.reg_dst;
  assign aluSrcB     = out_ctrl.alu_src_b;
  assign aluOp       = out_ctrl.alu_op;
  assign pcSource    = out_ctrl.pc_source;
  assign instrDone   = out_ctrl.instr_done;
  assign illegal     = out_ctrl.illegal;
  assign state       = STATE_W'(dec_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class, stalls,
// illegal opcodes and mid-instruction reset against hand-computed expectations.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg;
  logic       aluSrcA, regWrite, bne, instrDone, illegal;
  logic [1:0] regDst, aluSrcB, aluOp, pcSource;
  logic [3:0] state;

  int tests = 0;
  int fails = 0;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
    S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECUTE = 4'd6,
    S_ALUWB = 4'd7, S_BRANCH = 4'd8, S_ADDIEXEC = 4'd9, S_ADDIWB = 4'd10,
    S_JUMP = 4'd11;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .aluSrcA(aluSrcA),
    .regWrite(regWrite), .bne(bne), .regDst(regDst), .aluSrcB(aluSrcB),
    .aluOp(aluOp), .pcSource(pcSource), .instrDone(instrDone), .illegal(illegal),
    .state(state)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'b000000; memReady = 1'b1;
    cyc(); cyc();
    chk("rst_state", 8'(state), 8'(S_FETCH));
    chk("rst_memread", 8'(memRead), 8'd1);
    chk("rst_alusrcb", 8'(aluSrcB), 8'd1);
    chk("rst_irwrite", 8'(irWrite), 8'd0);
    chk("rst_pcwrite", 8'(pcWrite), 8'd0);
    chk("rst_done", 8'(instrDone), 8'd0);

    // lw, with a stray opcode change after DECODE
    rst = 1'b0; opcode = 6'b100011; #1;
    chk("lw_c1_state", 8'(state), 8'(S_FETCH));
    chk("lw_c1_irwrite", 8'(irWrite), 8'd1);
    chk("lw_c1_pcwrite", 8'(pcWrite), 8'd1);
    cyc();
    chk("lw_c2_state", 8'(state), 8'(S_DECODE));
    chk("lw_c2_alusrcb", 8'(aluSrcB), 8'd3);
    chk("lw_c2_illegal", 8'(illegal), 8'd0);
    cyc();
    opcode = 6'b000000; #1;
    chk("lw_c3_state", 8'(state), 8'(S_MEMADR));
    chk("lw_c3_sel", 8'({aluSrcA, aluSrcB}), 8'b110);
    cyc();
    chk("lw_c4_state", 8'(state), 8'(S_MEMREAD));
    chk("lw_c4_mem", 8'({memRead, iorD}), 8'b11);
    chk("lw_c4_done", 8'(instrDone), 8'd0);
    cyc();
    chk("lw_c5_state", 8'(state), 8'(S_MEMWB));
    chk("lw_c5_wb", 8'({regWrite, memToReg, instrDone}), 8'b111);
    chk("lw_c5_regdst", 8'(regDst), 8'd0);

    // sw with three MEMWRITE stall cycles
    opcode = 6'b101011;
    cyc();
    chk("sw_c1_state", 8'(state), 8'(S_FETCH));
    chk("sw_c1_done", 8'(instrDone), 8'd0);
    cyc(); chk("sw_c2_state", 8'(state), 8'(S_DECODE));
    cyc(); chk("sw_c3_state", 8'(state), 8'(S_MEMADR));
    cyc();
    memReady = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("sw_stall_state", 8'(state), 8'(S_MEMWRITE));
      chk("sw_stall_wr", 8'({memWrite, iorD, instrDone}), 8'b110);
      cyc();
    end
    memReady = 1'b1; #1;
    chk("sw_c7_state", 8'(state), 8'(S_MEMWRITE));
    chk("sw_c7_wr", 8'({memWrite, instrDone, regWrite}), 8'b110);
    cyc();
    chk("sw_end_state", 8'(state), 8'(S_FETCH));
    chk("sw_end_wr", 8'(memWrite), 8'd0);

    // bne then beq
    opcode = 6'b000101;
    cyc(); chk("bne_c2_state", 8'(state), 8'(S_DECODE));
    cyc();
    chk("bne_c3_state", 8'(state), 8'(S_BRANCH));
    chk("bne_c3_ctl", 8'({pcWriteCond, pcSource, bne, instrDone}), 8'b10111);
    chk("bne_c3_alu", 8'({aluSrcA, aluSrcB, aluOp}), 8'b10001);
    opcode = 6'b000100;
    cyc(); chk("beq_c1_state", 8'(state), 8'(S_FETCH));
    cyc(); cyc();
    chk("beq_c3_state", 8'(state), 8'(S_BRANCH));
    chk("beq_c3_ctl", 8'({pcWriteCond, pcSource, bne, instrDone}), 8'b10101);

    // illegal opcode
    opcode = 6'b111111;
    cyc(); cyc();
    chk("ill_state", 8'(state), 8'(S_DECODE));
    chk("ill_flags", 8'({illegal, instrDone, regWrite, memWrite}), 8'b1100);
    cyc();
    chk("ill_next_state", 8'(state), 8'(S_FETCH));
    chk("ill_next_flags", 8'({illegal, instrDone, regWrite, memWrite}), 8'b0000);

    // reset during MEMREAD of lw, then R-type
    opcode = 6'b100011;
    cyc(); cyc(); cyc();
    chk("rlw_state", 8'(state), 8'(S_MEMREAD));
    rst = 1'b1; #1;
    chk("rlw_rst_outs", 8'({memRead, iorD, regWrite, instrDone}), 8'b1000);
    cyc();
    chk("rlw_after_state", 8'(state), 8'(S_FETCH));
    chk("rlw_after_wr", 8'(regWrite), 8'd0);
    rst = 1'b0; opcode = 6'b000000; #1;
    chk("r_c1_ir", 8'(irWrite), 8'd1);
    cyc(); chk("r_c2_state", 8'(state), 8'(S_DECODE));
    cyc();
    chk("r_c3_state", 8'(state), 8'(S_EXECUTE));
    chk("r_c3_alu", 8'({aluSrcA, aluSrcB, aluOp}), 8'b10010);
    cyc();
    chk("r_c4_state", 8'(state), 8'(S_ALUWB));
    chk("r_c4_wb", 8'({regDst, regWrite, instrDone}), 8'b0111);
    cyc();
    chk("r_end_state", 8'(state), 8'(S_FETCH));

    // fetch stall: two cycles of memReady=0, then a single ir/pc write
    opcode = 6'b000010; memReady = 1'b0; #1;
    for (int i = 0; i < 2; i++) begin
      chk("fs_state", 8'(state), 8'(S_FETCH));
      chk("fs_wr", 8'({irWrite, pcWrite, memRead}), 8'b001);
      cyc();
    end
    memReady = 1'b1; #1;
    chk("fs_go_wr", 8'({irWrite, pcWrite}), 8'b11);
    cyc();
    chk("fs_dec_state", 8'(state), 8'(S_DECODE));
    chk("fs_dec_wr", 8'({irWrite, pcWrite}), 8'b00);
    cyc();
    chk("j_state", 8'(state), 8'(S_JUMP));
    chk("j_ctl", 8'({pcWrite, pcSource, instrDone}), 8'b1101);

    // addi
    opcode = 6'b001000;
    cyc(); cyc(); cyc();
    chk("addi_c3_state", 8'(state), 8'(S_ADDIEXEC));
    chk("addi_c3_sel", 8'({aluSrcA, aluSrcB, aluOp}), 8'b11000);
    cyc();
    chk("addi_c4_state", 8'(state), 8'(S_ADDIWB));
    chk("addi_c4_wb", 8'({regDst, regWrite, instrDone, memToReg}), 8'b00110);
    cyc();
    chk("addi_end_state", 8'(state), 8'(S_FETCH));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
